// File: rtl/tlb_op_ctrl_pkg.sv
// Shared definitions for the TLB maintenance sequencer and the TLB array.
// Contains the operation encoding, the controller state encoding and the default entry count.
package tlb_op_ctrl_pkg;

    localparam int TLB_NUM_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_TLBP  = 2'd0,
        OP_TLBR  = 2'd1,
        OP_TLBWI = 2'd2,
        OP_TLBWR = 2'd3
    } tlb_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_COMMIT = 3'd2,
        ST_WRITE  = 3'd3,
        ST_FLUSH  = 3'd4
    } state_t;

endpackage

// File: rtl/tlb_op_ctrl_if.sv
// Request channel from CP0/commit into the TLB sequencer.
// Handshake: an operation transfers on a clock edge where op_valid && op_ready; op_done pulses once when it completes.
interface tlb_op_ctrl_if;

    logic                     op_valid;
    tlb_op_ctrl_pkg::tlb_op_t op_type;
    logic                     op_ready;
    logic                     op_kill;
    logic                     op_done;

    modport master (output op_valid, op_type, op_kill, input op_ready, op_done);
    modport slave  (input op_valid, op_type, op_kill, output op_ready, op_done);

endinterface

// File: rtl/tlb_random_ctr.sv
// CP0 Random: counts down from TLB_NUM-1 to Wired and wraps back to TLB_NUM-1.
// It is held during a TLB write so that the index a TLBWR sampled stays consistent with the register.
module tlb_random_ctr #(
    parameter int TLB_NUM  = 32,
    parameter int IDX_BITS = $clog2(TLB_NUM)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wired_we_i,
    input  logic [IDX_BITS-1:0] wired_i,
    input  logic                freeze_i,
    output logic [IDX_BITS-1:0] random_o
);

    localparam logic [IDX_BITS-1:0] TOP = IDX_BITS'(TLB_NUM - 1);

    logic [IDX_BITS-1:0] random_q;
    logic [IDX_BITS-1:0] random_d;

    always_comb begin
        random_d = random_q;
        if (wired_we_i) begin
            random_d = TOP;
        end else if (!freeze_i) begin
            if ((random_q == wired_i) || (wired_i >= TOP)) begin
                random_d = TOP;
            end else begin
                random_d = random_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            random_q <= TOP;
        end else begin
            random_q <= random_d;
        end
    end

    assign random_o = random_q;

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBP/TLBR/TLBWI/TLBWR: drives the TLB array index and write strobe,
// returns probe/read results to CP0 and pulses a translation flush after each write.
module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter int TLB_NUM  = TLB_NUM_DEFAULT,
    parameter int IDX_BITS = $clog2(TLB_NUM)
) (
    input  logic                clk,
    input  logic                rst,
    tlb_op_ctrl_if.slave        op,
    input  logic [IDX_BITS-1:0] cp0_index_i,
    input  logic [IDX_BITS-1:0] cp0_wired_i,
    input  logic                wired_we_i,
    output logic                tlb_we_o,
    output logic [IDX_BITS-1:0] tlb_index_o,
    input  logic [31:0]         tlb_probe_i,
    output logic                index_we_o,
    output logic [31:0]         index_wdata_o,
    output logic                read_we_o,
    output logic [IDX_BITS-1:0] random_o,
    output logic                tlb_flush_o,
    output state_t              dbg_state_o
);

    state_t              state_q, state_d;
    tlb_op_t             op_q, op_d;
    logic [IDX_BITS-1:0] idx_q, idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                we_q, we_d;
    logic                index_we_q, index_we_d;
    logic                read_we_q, read_we_d;
    logic                flush_q, flush_d;

    // Probe bits between the miss flag and the index field never reach CP0 Index.
    logic unused_probe_bits;
    assign unused_probe_bits = ^tlb_probe_i[30:IDX_BITS];

    tlb_random_ctr #(.TLB_NUM(TLB_NUM), .IDX_BITS(IDX_BITS)) u_random (
        .clk        (clk),
        .rst        (rst),
        .wired_we_i (wired_we_i),
        .wired_i    (cp0_wired_i),
        .freeze_i   (state_q == ST_WRITE),
        .random_o   (random_o)
    );

    // Strobes are computed for the state being entered so every output leaves a flop.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        we_d       = 1'b0;
        index_we_d = 1'b0;
        read_we_d  = 1'b0;
        flush_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op.op_valid) begin
                    op_d  = op.op_type;
                    idx_d = (op.op_type == OP_TLBWR) ? random_o : cp0_index_i;
                    if ((op.op_type == OP_TLBP) || (op.op_type == OP_TLBR)) begin
                        state_d = ST_LOOKUP;
                    end else begin
                        state_d = ST_WRITE;
                        we_d    = 1'b1;
                    end
                end
            end
            ST_LOOKUP: begin
                if (op.op_kill) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_COMMIT;
                    done_d  = 1'b1;
                    if (op_q == OP_TLBP) begin
                        index_we_d                = 1'b1;
                        wdata_d                   = '0;
                        wdata_d[31]               = tlb_probe_i[31];
                        wdata_d[IDX_BITS-1:0]     = tlb_probe_i[IDX_BITS-1:0];
                    end else begin
                        read_we_d = 1'b1;
                    end
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            ST_WRITE: begin
                state_d = ST_FLUSH;
                flush_d = 1'b1;
                done_d  = 1'b1;
            end
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_TLBP;
            idx_q      <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            index_we_q <= 1'b0;
            read_we_q  <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            we_q       <= we_d;
            index_we_q <= index_we_d;
            read_we_q  <= read_we_d;
            flush_q    <= flush_d;
        end
    end

    assign op.op_ready   = (state_q == ST_IDLE);
    assign op.op_done    = done_q;
    assign tlb_we_o      = we_q;
    assign tlb_index_o   = idx_q;
    assign index_we_o    = index_we_q;
    assign index_wdata_o = wdata_q;
    assign read_we_o     = read_we_q;
    assign tlb_flush_o   = flush_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl: Random sequencing from a vector table plus
// hand-written sequences for each TLB operation, kill, and reset corner cases.
module tb_tlb_op_ctrl;
    import tlb_op_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  cp0_index;
    logic [4:0]  cp0_wired;
    logic        wired_we;
    logic        tlb_we;
    logic [4:0]  tlb_index;
    logic [31:0] tlb_probe;
    logic        index_we;
    logic [31:0] index_wdata;
    logic        read_we;
    logic [4:0]  random_v;
    logic        tlb_flush;
    state_t      dbg_state;
    logic [4:0]  strb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tlb_op_ctrl_if op_if ();

    tlb_op_ctrl #(.TLB_NUM(32), .IDX_BITS(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .op            (op_if),
        .cp0_index_i   (cp0_index),
        .cp0_wired_i   (cp0_wired),
        .wired_we_i    (wired_we),
        .tlb_we_o      (tlb_we),
        .tlb_index_o   (tlb_index),
        .tlb_probe_i   (tlb_probe),
        .index_we_o    (index_we),
        .index_wdata_o (index_wdata),
        .read_we_o     (read_we),
        .random_o      (random_v),
        .tlb_flush_o   (tlb_flush),
        .dbg_state_o   (dbg_state)
    );

    // {op_done, tlb_we, index_we, read_we, tlb_flush}
    assign strb = {op_if.op_done, tlb_we, index_we, read_we, tlb_flush};

    typedef struct {
        logic       we;
        logic [4:0] wired;
        logic [4:0] exp_random;
    } rvec_t;

    rvec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input tlb_op_t t, input logic [4:0] idx);
        chk("ready_before_accept", {31'd0, op_if.op_ready}, 32'd1);
        op_if.op_valid = 1'b1;
        op_if.op_type  = t;
        cp0_index      = idx;
        step();
        op_if.op_valid = 1'b0;
    endtask

    task automatic wait_random(input logic [4:0] v);
        int n = 0;
        while (random_v !== v && n < 64) begin
            step();
            n++;
        end
        chk("wait_random", {27'd0, random_v}, {27'd0, v});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, 5'd28, 5'd31};
        tbl[1]  = '{1'b0, 5'd28, 5'd30};
        tbl[2]  = '{1'b0, 5'd28, 5'd29};
        tbl[3]  = '{1'b0, 5'd28, 5'd28};
        tbl[4]  = '{1'b0, 5'd28, 5'd31};
        tbl[5]  = '{1'b0, 5'd28, 5'd30};
        tbl[6]  = '{1'b1, 5'd5,  5'd31};
        tbl[7]  = '{1'b0, 5'd5,  5'd30};
        tbl[8]  = '{1'b0, 5'd5,  5'd29};
        tbl[9]  = '{1'b1, 5'd31, 5'd31};
        tbl[10] = '{1'b0, 5'd31, 5'd31};
        tbl[11] = '{1'b0, 5'd31, 5'd31};
        tbl[12] = '{1'b1, 5'd0,  5'd31};

        rst            = 1'b1;
        op_if.op_valid = 1'b0;
        op_if.op_type  = OP_TLBP;
        op_if.op_kill  = 1'b0;
        cp0_index      = 5'd0;
        cp0_wired      = 5'd0;
        wired_we       = 1'b0;
        tlb_probe      = 32'd0;
        repeat (2) @(posedge clk);
        #1;

        chk("reset_strobes", {27'd0, strb}, 32'd0);
        chk("reset_ready", {31'd0, op_if.op_ready}, 32'd1);
        chk("reset_index", {27'd0, tlb_index}, 32'd0);
        chk("reset_wdata", index_wdata, 32'd0);
        chk("reset_random", {27'd0, random_v}, 32'd31);
        chk("reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        rst = 1'b0;

        // Idle with Wired=0: 31,30,...,0,31,...
        for (int k = 1; k <= 40; k++) begin
            step();
            chk("idle_random", {27'd0, random_v}, 32'(31 - (k % 32)));
            chk("idle_strobes", {27'd0, strb}, 32'd0);
        end

        for (int i = 0; i < 13; i++) begin
            wired_we  = tbl[i].we;
            cp0_wired = tbl[i].wired;
            step();
            chk($sformatf("tbl_random[%0d]", i), {27'd0, random_v}, {27'd0, tbl[i].exp_random});
        end
        wired_we = 1'b0;

        // TLBWI index 7, Random=31 at accept
        accept(OP_TLBWI, 5'd7);
        chk("wi_write_strobes", {27'd0, strb}, 32'b01000);
        chk("wi_write_index", {27'd0, tlb_index}, 32'd7);
        chk("wi_write_ready", {31'd0, op_if.op_ready}, 32'd0);
        chk("wi_write_random", {27'd0, random_v}, 32'd30);
        step();
        chk("wi_flush_strobes", {27'd0, strb}, 32'b10001);
        chk("wi_flush_ready", {31'd0, op_if.op_ready}, 32'd0);
        chk("wi_flush_random", {27'd0, random_v}, 32'd30);
        step();
        chk("wi_idle_strobes", {27'd0, strb}, 32'd0);
        chk("wi_idle_ready", {31'd0, op_if.op_ready}, 32'd1);
        chk("wi_idle_random", {27'd0, random_v}, 32'd29);
        chk("wi_idle_index_held", {27'd0, tlb_index}, 32'd7);

        // TLBP hit, then miss, then junk in the middle bits; back-to-back
        accept(OP_TLBP, 5'd9);
        chk("p_lookup_index", {27'd0, tlb_index}, 32'd9);
        chk("p_lookup_strobes", {27'd0, strb}, 32'd0);
        tlb_probe = 32'h0000_0005;
        step();
        chk("p_hit_strobes", {27'd0, strb}, 32'b10100);
        chk("p_hit_wdata", index_wdata, 32'h0000_0005);
        step();
        chk("p_hit_after", {27'd0, strb}, 32'd0);
        accept(OP_TLBP, 5'd9);
        tlb_probe = 32'h8000_0000;
        step();
        chk("p_miss_strobes", {27'd0, strb}, 32'b10100);
        chk("p_miss_wdata", index_wdata, 32'h8000_0000);
        step();
        accept(OP_TLBP, 5'd9);
        tlb_probe = 32'h8000_1234;
        step();
        chk("p_mask_wdata", index_wdata, 32'h8000_0014);
        step();

        // TLBR killed in LOOKUP, then completed
        accept(OP_TLBR, 5'd3);
        op_if.op_kill = 1'b1;
        step();
        op_if.op_kill = 1'b0;
        chk("r_kill_strobes", {27'd0, strb}, 32'd0);
        chk("r_kill_ready", {31'd0, op_if.op_ready}, 32'd1);
        accept(OP_TLBR, 5'd3);
        step();
        chk("r_commit_strobes", {27'd0, strb}, 32'b10010);
        chk("r_commit_index", {27'd0, tlb_index}, 32'd3);
        step();
        chk("r_after_strobes", {27'd0, strb}, 32'd0);

        // TLBWR sampled at Random=12
        wait_random(5'd12);
        accept(OP_TLBWR, 5'd7);
        chk("wr_write_strobes", {27'd0, strb}, 32'b01000);
        chk("wr_write_index", {27'd0, tlb_index}, 32'd12);
        chk("wr_write_random", {27'd0, random_v}, 32'd11);
        step();
        chk("wr_flush_strobes", {27'd0, strb}, 32'b10001);
        chk("wr_frozen_random", {27'd0, random_v}, 32'd11);
        step();
        chk("wr_resume_random", {27'd0, random_v}, 32'd10);

        // TLBWR accepted with a Wired write in the same cycle
        wait_random(5'd20);
        wired_we = 1'b1;
        accept(OP_TLBWR, 5'd1);
        wired_we = 1'b0;
        chk("wrw_index", {27'd0, tlb_index}, 32'd20);
        chk("wrw_random", {27'd0, random_v}, 32'd31);
        step();
        chk("wrw_frozen_random", {27'd0, random_v}, 32'd31);
        step();

        // op_kill during WRITE has no effect
        accept(OP_TLBWI, 5'd4);
        op_if.op_kill = 1'b1;
        step();
        op_if.op_kill = 1'b0;
        chk("wkill_flush_strobes", {27'd0, strb}, 32'b10001);
        step();

        // Reset while in WRITE
        accept(OP_TLBWI, 5'd9);
        chk("rstw_write_strobes", {27'd0, strb}, 32'b01000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw_strobes", {27'd0, strb}, 32'd0);
        chk("rstw_ready", {31'd0, op_if.op_ready}, 32'd1);
        chk("rstw_index", {27'd0, tlb_index}, 32'd0);
        chk("rstw_random", {27'd0, random_v}, 32'd31);
        step();
        chk("rstw_after_strobes", {27'd0, strb}, 32'd0);
        chk("rstw_after_random", {27'd0, random_v}, 32'd30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
